// File: rtl/aipp_token_pkg.sv
// aipp_token_pkg: temporal token layout, issuer FSM states and sequence helpers shared by issuer and dispatcher
package aipp_token_pkg;

    localparam int TS_LSB    = 64;
    localparam int SEQ_LSB   = 32;
    localparam int GPU_LSB   = 24;
    localparam int UNITS_LSB = 16;
    localparam int EXP_LSB   = 0;

    localparam int TS_W    = 64;
    localparam int SEQ_W   = 32;
    localparam int GPU_W   = 8;
    localparam int UFLD_W  = 8;
    localparam int EXP_W   = 16;

    localparam logic [SEQ_W-1:0] SEQ_INIT = 32'h1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        DENY,
        GAP
    } state_e;

    // Sequence skips zero on wrap so the low token half is never all-zero
    function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] s);
        return (s == '1) ? SEQ_INIT : s + 32'd1;
    endfunction

endpackage

// File: rtl/aipp_budget_accumulator.sv
// aipp_budget_accumulator: committed power-unit ledger with saturating add/release and admit compare
module aipp_budget_accumulator #(
    parameter int UNITS_W  = 8,
    parameter int BUDGET_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                add_valid,
    input  logic [UNITS_W-1:0]  add_units,
    input  logic                rel_valid,
    input  logic [UNITS_W-1:0]  rel_units,
    input  logic [UNITS_W-1:0]  chk_units,
    input  logic [BUDGET_W-1:0] budget_limit,
    output logic [BUDGET_W-1:0] committed,
    output logic                admit
);

    localparam int SW = BUDGET_W + 1;

    logic [BUDGET_W-1:0] committed_q, committed_d;
    logic [SW-1:0]       plus, minus;

    // Apply grant and release together at one extra bit, clamping underflow to zero
    always_comb begin
        plus        = {1'b0, committed_q} + (add_valid ? SW'(add_units) : '0);
        minus       = rel_valid ? SW'(rel_units) : '0;
        committed_d = (plus > minus) ? BUDGET_W'(plus - minus) : '0;
        admit       = (chk_units != '0) && (({1'b0, committed_q} + SW'(chk_units)) <= {1'b0, budget_limit});
    end

    // Ledger register
    always_ff @(posedge clk) begin
        committed_q <= rst ? '0 : committed_d;
    end

    assign committed = committed_q;

endmodule

// File: rtl/aipp_temporal_token_issuer.sv
// aipp_temporal_token_issuer: admits GPU compute requests against a power budget and issues ramp-spaced temporal tokens
module aipp_temporal_token_issuer
    import aipp_token_pkg::*;
#(
    parameter int LEASE_CYCLES = 1024,
    parameter int RAMP_GAP     = 16,
    parameter int UNITS_W      = 8,
    parameter int BUDGET_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          req_gpu_id,
    input  logic [UNITS_W-1:0]  req_units,
    input  logic [BUDGET_W-1:0] budget_limit,
    input  logic                rel_valid,
    input  logic [UNITS_W-1:0]  rel_units,
    output logic                tok_valid,
    input  logic                tok_ready,
    output logic [127:0]        tok_data,
    output logic                deny_pulse,
    output logic [BUDGET_W-1:0] committed
);

    state_e              state_q, state_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [15:0]         gap_q, gap_d;
    logic [GPU_W-1:0]    gpu_q, gpu_d;
    logic [UNITS_W-1:0]  units_q, units_d;
    logic [127:0]        tok_q, tok_d;
    logic                ready_q, ready_d;
    logic                accept;
    logic                admit;

    aipp_budget_accumulator #(
        .UNITS_W  (UNITS_W),
        .BUDGET_W (BUDGET_W)
    ) u_acc (
        .clk          (clk),
        .rst          (rst),
        .add_valid    (accept),
        .add_units    (units_q),
        .rel_valid    (rel_valid),
        .rel_units    (rel_units),
        .chk_units    (units_q),
        .budget_limit (budget_limit),
        .committed    (committed),
        .admit        (admit)
    );

    // Request/grant FSM; token is frozen on ISSUE entry and the gap counter spans the ramp window
    always_comb begin
        state_d = state_q;
        ts_d    = ts_q + 64'd1;
        seq_d   = seq_q;
        gap_d   = gap_q;
        gpu_d   = gpu_q;
        units_d = units_q;
        tok_d   = tok_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    gpu_d   = req_gpu_id;
                    units_d = req_units;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = admit ? ISSUE : DENY;
                if (admit) begin
                    tok_d[TS_LSB +: TS_W]       = ts_q;
                    tok_d[SEQ_LSB +: SEQ_W]     = seq_q;
                    tok_d[GPU_LSB +: GPU_W]     = gpu_q;
                    tok_d[UNITS_LSB +: UFLD_W]  = UFLD_W'(units_q);
                    tok_d[EXP_LSB +: EXP_W]     = ts_q[EXP_W-1:0] + EXP_W'(LEASE_CYCLES);
                end
            end
            ISSUE: begin
                if (tok_ready) begin
                    accept  = 1'b1;
                    seq_d   = seq_next(seq_q);
                    gap_d   = 16'(RAMP_GAP - 1);
                    state_d = GAP;
                end
            end
            DENY: state_d = IDLE;
            GAP: begin
                state_d = (gap_q == '0) ? IDLE : GAP;
                gap_d   = (gap_q == '0) ? gap_q : gap_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ts_q    <= '0;
            seq_q   <= SEQ_INIT;
            gap_q   <= '0;
            gpu_q   <= '0;
            units_q <= '0;
            tok_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            seq_q   <= seq_d;
            gap_q   <= gap_d;
            gpu_q   <= gpu_d;
            units_q <= units_d;
            tok_q   <= tok_d;
            ready_q <= ready_d;
        end
    end

    assign req_ready  = ready_q;
    assign tok_valid  = (state_q == ISSUE);
    assign tok_data   = tok_q;
    assign deny_pulse = (state_q == DENY);

endmodule

// File: tb/tb_aipp_temporal_token_issuer.sv
// tb_aipp_temporal_token_issuer: table-driven request vectors with a token scoreboard plus reset and wrap sequences
module tb_aipp_temporal_token_issuer;

    localparam int RAMP_GAP = 16;
    localparam int LEASE    = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [7:0]   req_gpu_id = '0;
    logic [7:0]   req_units = '0;
    logic [15:0]  budget_limit = '0;
    logic         rel_valid = 1'b0;
    logic [7:0]   rel_units = '0;
    logic         tok_valid;
    logic         tok_ready = 1'b0;
    logic [127:0] tok_data;
    logic         deny_pulse;
    logic [15:0]  committed;

    typedef struct {
        logic [7:0]  gpu;
        logic [7:0]  units;
        logic [15:0] budget;
        logic [7:0]  pre_rel;
        logic [7:0]  rel;
        int          hold;
        bit          grant;
        logic [15:0] comm;
    } vec_t;

    typedef struct {
        logic [31:0] seq;
        logic [7:0]  gpu;
        logic [7:0]  units;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[11];
    int          tests = 0;
    int          fails = 0;
    logic [63:0] ts_m = '0;
    logic [31:0] seq_m = 32'h1;
    logic [15:0] comm_m = '0;

    aipp_temporal_token_issuer #(
        .LEASE_CYCLES (LEASE),
        .RAMP_GAP     (RAMP_GAP),
        .UNITS_W      (8),
        .BUDGET_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_gpu_id   (req_gpu_id),
        .req_units    (req_units),
        .budget_limit (budget_limit),
        .rel_valid    (rel_valid),
        .rel_units    (rel_units),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_data     (tok_data),
        .deny_pulse   (deny_pulse),
        .committed    (committed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ts_m <= rst ? 64'd0 : ts_m + 64'd1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, req_ready, 1);
    endtask

    task automatic send(input vec_t v);
        exp_t         e;
        logic [127:0] t0;
        logic [63:0]  ts_cap;
        int           n;
        budget_limit = v.budget;
        if (v.pre_rel != 0) begin
            rel_valid = 1'b1;
            rel_units = v.pre_rel;
            @(negedge clk);
            rel_valid = 1'b0;
            comm_m = (comm_m > 16'(v.pre_rel)) ? comm_m - 16'(v.pre_rel) : 16'd0;
            check("pre_release_committed", committed, comm_m);
        end
        wait_ready("req_ready_before_request");
        if (v.grant) sb.push_back('{seq_m, v.gpu, v.units});
        req_valid  = 1'b1;
        req_gpu_id = v.gpu;
        req_units  = v.units;
        @(negedge clk);
        req_valid = 1'b0;
        check("check_cycle_tok_valid", tok_valid, 0);
        check("check_cycle_deny", deny_pulse, 0);
        @(negedge clk);
        if (v.grant) begin
            check("grant_tok_valid", tok_valid, 1);
            check("grant_no_deny", deny_pulse, 0);
            if (sb.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                ts_cap = ts_m - 64'd1;
                check("tok_seq", tok_data[63:32], e.seq);
                check("tok_gpu", tok_data[31:24], e.gpu);
                check("tok_units", tok_data[23:16], e.units);
                check("tok_timestamp", tok_data[127:64], ts_cap);
                check("tok_expiry", tok_data[15:0], ts_cap[15:0] + 16'(LEASE));
                check("tok_low_nonzero", tok_data[63:0] != 64'd0, 1);
            end
            t0 = tok_data;
            for (int i = 0; i < v.hold; i++) begin
                @(negedge clk);
                check("hold_tok_valid", tok_valid, 1);
                check("hold_tok_stable", tok_data, t0);
            end
            tok_ready = 1'b1;
            rel_valid = (v.rel != 0);
            rel_units = v.rel;
            @(negedge clk);
            tok_ready = 1'b0;
            rel_valid = 1'b0;
            seq_m  = (seq_m == 32'hFFFF_FFFF) ? 32'h1 : seq_m + 32'd1;
            comm_m = v.comm;
            check("accept_committed", committed, v.comm);
            check("accept_tok_valid_drops", tok_valid, 0);
            n = 0;
            while (!req_ready && n < 100) begin
                n++;
                @(negedge clk);
            end
            check("ramp_gap_cycles", n, RAMP_GAP);
        end else begin
            check("deny_pulse_high", deny_pulse, 1);
            check("deny_no_tok", tok_valid, 0);
            @(negedge clk);
            check("deny_pulse_one_cycle", deny_pulse, 0);
            check("deny_ready_back", req_ready, 1);
            check("deny_committed", committed, v.comm);
        end
    endtask

    initial begin
        //           gpu    units  budget     pre   rel   hold grant comm
        vecs[0]  = '{8'h05, 8'd40,  16'd100,    8'd0,   8'd0,  5, 1, 16'd40};
        vecs[1]  = '{8'h06, 8'd40,  16'd100,    8'd0,   8'd0,  0, 1, 16'd80};
        vecs[2]  = '{8'h07, 8'd30,  16'd100,    8'd0,   8'd0,  0, 0, 16'd80};
        vecs[3]  = '{8'h08, 8'd0,   16'd100,    8'd0,   8'd0,  0, 0, 16'd80};
        vecs[4]  = '{8'h09, 8'd20,  16'd100,    8'd0,   8'd0,  2, 1, 16'd100};
        vecs[5]  = '{8'h01, 8'd1,   16'd100,    8'd0,   8'd0,  0, 0, 16'd100};
        vecs[6]  = '{8'h02, 8'd20,  16'd100,    8'd50,  8'd30, 0, 1, 16'd40};
        vecs[7]  = '{8'h04, 8'd10,  16'd100,    8'd255, 8'd0,  0, 1, 16'd10};
        vecs[8]  = '{8'h0A, 8'd1,   16'd5,      8'd0,   8'd0,  0, 0, 16'd10};
        vecs[9]  = '{8'h0B, 8'd1,   16'd5,      8'd6,   8'd0,  0, 1, 16'd5};
        vecs[10] = '{8'hC3, 8'd255, 16'hFFFF,   8'd0,   8'd0,  0, 1, 16'd260};

        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        check("reset_tok_valid", tok_valid, 0);
        check("reset_tok_data", tok_data, 0);
        check("reset_deny", deny_pulse, 0);
        check("reset_committed", committed, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", req_ready, 1);

        for (int i = 0; i < 11; i++) send(vecs[i]);

        force dut.seq_q = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.seq_q;
        seq_m = 32'hFFFF_FFFF;
        send('{8'h11, 8'd1, 16'hFFFF, 8'd0, 8'd0, 0, 1, 16'd261});
        send('{8'h12, 8'd1, 16'hFFFF, 8'd0, 8'd0, 0, 1, 16'd262});

        wait_ready("rst_seq_ready");
        budget_limit = 16'hFFFF;
        req_valid  = 1'b1;
        req_gpu_id = 8'h33;
        req_units  = 8'd2;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_seq_in_issue", tok_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tok_valid", tok_valid, 0);
        check("rst_mid_committed", committed, 0);
        check("rst_mid_req_ready", req_ready, 0);
        check("rst_mid_tok_data", tok_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", req_ready, 1);
        seq_m  = 32'h1;
        comm_m = '0;
        sb.delete();
        send('{8'h22, 8'd3, 16'd100, 8'd0, 8'd0, 0, 1, 16'd3});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aipp_temporal_token_issuer.md
Name: aipp_temporal_token_issuer

Overview:
Switch-side issuer of the 128-bit Temporal Tokens consumed by the GPU-side clock-gated dispatcher. Accepts per-GPU compute-permission requests and admits them against a PMU-supplied power budget. Spaces grants by a minimum ramp gap to bound aggregate di/dt. Emits tokens whose low 64 bits are guaranteed non-zero, so that the dispatcher's validity check passes only for issued tokens.

Parameters:
LEASE_CYCLES, 1024, lease length added to the issue time to form the expiry field.
RAMP_GAP, 16, minimum cycles from one token acceptance to the next request acceptance; legal range 1..65535.
UNITS_W, 8, width of a requested or released power-unit count.
BUDGET_W, 16, width of the budget limit and of the committed-units accumulator.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  issuer can accept a request
req_gpu_id  in  8  requesting GPU id
req_units  in  UNITS_W  power units requested
budget_limit  in  BUDGET_W  current PMU power budget; sampled in CHECK
rel_valid  in  1  single-cycle release strobe from a finished kernel
rel_units  in  UNITS_W  units released
tok_valid  out  1  token presented
tok_ready  in  1  downstream (AIPP-Omega header inserter) accepts the token
tok_data  out  128  temporal token
deny_pulse  out  1  one-cycle strobe when a request is refused
committed  out  BUDGET_W  units currently leased

Behaviour:
- Reset (synchronous, rst high at a clk edge) clears all state:
  - req_ready=0, tok_valid=0, tok_data=0, deny_pulse=0, committed=0.
  - seq=1, timestamp=0, gap counter=0, state=IDLE.
  - A reset mid-operation abandons any pending token. That token is never presented.
- Free-running 64-bit timestamp increments every cycle when not in reset and wraps naturally.
- FSM states: IDLE, CHECK, ISSUE, DENY, GAP.
  - IDLE: req_ready=1. On req_valid&req_ready, latch gpu_id and units, then go to CHECK.
  - CHECK (1 cycle): grant iff req_units!=0 and committed+req_units <= budget_limit. The sum is computed at BUDGET_W+1 bits, so there is no overflow. Grant goes to ISSUE. Otherwise go to DENY.
  - DENY (1 cycle): deny_pulse=1, then go to IDLE. No GAP on deny.
  - ISSUE: tok_valid=1. tok_data is registered on entry and held stable until tok_ready.
    - On tok_valid&tok_ready: committed += units, seq advances, go to GAP.
  - GAP: count RAMP_GAP cycles from the acceptance edge, then go to IDLE.
- Latency:
  - Grant: request accepted at cycle N; tok_valid asserted at cycle N+2.
  - Deny: deny_pulse at cycle N+2.
  - Next req_ready: RAMP_GAP cycles after token acceptance.
- Token layout:
  - [127:64] timestamp captured on ISSUE entry.
  - [63:32] seq.
  - [31:24] gpu_id.
  - [23:16] units, zero-extended or truncated to 8 bits.
  - [15:0] (timestamp[15:0]+LEASE_CYCLES) mod 2^16.
- seq rules:
  - seq wraps 0xFFFFFFFF -> 0x00000001; 0 is never issued. This guarantees tok_data[63:0]!=0.
  - seq advances only on acceptance, never on deny.
- Release:
  - On rel_valid, committed -= rel_units, saturating at 0.
  - Same-cycle release and token acceptance: both are applied, i.e. committed+units-rel_units, saturating at 0.
  - Releases are honoured in every state except reset.
- budget_limit changes:
  - A decrease below committed does not revoke existing leases.
  - It causes every subsequent non-zero request to be denied until releases bring committed back within budget.
- committed never exceeds 2^BUDGET_W-1. This is guaranteed by the CHECK rule.
- req_units=0 is denied.

Decomposition:
- Package aipp_token_pkg holds:
  - Token field offsets and widths: TS_LSB=64, SEQ_LSB=32, GPU_LSB=24, UNITS_LSB=16, EXP_LSB=0.
  - FSM state enum.
  - SEQ_INIT=32'h1.
- The GPU-side dispatcher shares the same package.
- One sub-module, aipp_budget_accumulator, contains:
  - the saturating add/subtract of committed;
  - the admit compare.
- The FSM, seq, timestamp and gap counter stay in the top module.

Test Plan:
1. Grant path: budget_limit=100, req gpu=5 units=40 at cycle N -> tok_valid at N+2 with tok_data[63:32]=1, [31:24]=0x05, [23:16]=0x28, [15:0]=ts[15:0]+1024; after accept, committed=40.
2. Budget deny: committed=80, budget_limit=100, req units=30 -> deny_pulse high exactly one cycle at N+2; committed stays 80; seq unchanged; req_ready back the following cycle.
3. Backpressure and ramp gap: hold tok_ready=0 for 5 cycles -> tok_data stable and tok_valid held; accept -> req_ready low for exactly RAMP_GAP=16 cycles, then high.
4. Simultaneous release and accept: committed=50, accept units=20 in the same cycle as rel_units=30 -> committed=40. Release of 255 with committed=40 -> committed=0, no underflow.
5. Sequence wrap: force seq=0xFFFFFFFF, issue two tokens -> fields 0xFFFFFFFF then 0x00000001; tok_data[63:0] never zero.
6. Reset mid-ISSUE: assert rst while tok_valid=1 and tok_ready=0 -> next edge gives tok_valid=0, committed=0, req_ready=0; after rst drops, req_ready=1 and the next token has seq=1.
